// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator floor scheduler.
package elevator_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int   FLOOR_W  = 4;
endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, stability counter, and a one-cycle
// pulse when the debounced level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q, level_q, rise_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive synchronised samples that disagree with level_q
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/elevator_floor_scheduler.sv
// SCAN (collective) elevator dispatcher: latches debounced floor calls,
// drives motor_run/motor_dir and tracks car position from step_tick pulses.
module elevator_floor_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 9,
  parameter int STEPS_PER_FLOOR = 48,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DOOR_CYCLES     = 48000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] push_btns,
  input  logic                  step_tick,
  output logic                  motor_run,
  output logic                  motor_dir,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);
  localparam int SCW = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
  localparam int TW  = $clog2(DOOR_CYCLES + 1);
  localparam logic [SCW-1:0]     LAST_STEP = SCW'(STEPS_PER_FLOOR - 1);
  localparam logic [TW-1:0]      DOOR_LOAD = TW'(DOOR_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  state_e                state_q;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, req_set;
  logic [FLOOR_W-1:0]    cur_floor_q, nf;
  logic [SCW-1:0]        step_cnt_q;
  logic [TW-1:0]         door_tmr_q;
  logic                  last_dir_q, motor_run_q, motor_dir_q, door_open_q;
  logic                  above_cur, below_cur, further, arrive;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (push_btns[g]),
      .rise_o (req_set[g])
    );
  end

  assign above_cur = any_above(pending_q, cur_floor_q);
  assign below_cur = any_below(pending_q, cur_floor_q);
  assign arrive    = (state_q == MOVE_UP || state_q == MOVE_DOWN) && step_tick &&
                     (step_cnt_q == LAST_STEP);

  // Floor reached on the next completed floor of travel, saturated at the shaft ends
  always_comb begin
    nf = cur_floor_q;
    if (state_q == MOVE_DOWN) begin
      if (cur_floor_q != '0) nf = cur_floor_q - FLOOR_W'(1);
    end else if (cur_floor_q != TOP_FLOOR) begin
      nf = cur_floor_q + FLOOR_W'(1);
    end
  end

  assign further = (state_q == MOVE_UP) ? any_above(pending_q, nf) : any_below(pending_q, nf);

  // Clears are applied after sets so a same-cycle set of a served floor is dropped
  always_comb begin
    set_mask = req_set;
    if (state_q == DOOR_OPEN) set_mask[cur_floor_q] = 1'b0;
    pending_d = pending_q | set_mask;
    if (state_q == IDLE && pending_q[cur_floor_q]) pending_d[cur_floor_q] = 1'b0;
    if (arrive && pending_q[nf]) pending_d[nf] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cur_floor_q <= '0;
      step_cnt_q  <= '0;
      door_tmr_q  <= '0;
      last_dir_q  <= DIR_UP;
      motor_run_q <= 1'b0;
      motor_dir_q <= DIR_UP;
      door_open_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (pending_q != '0) begin
            if (pending_q[cur_floor_q]) begin
              state_q     <= DOOR_OPEN;
              door_open_q <= 1'b1;
              door_tmr_q  <= DOOR_LOAD;
            end else if (above_cur && (last_dir_q == DIR_UP || !below_cur)) begin
              state_q     <= MOVE_UP;
              motor_run_q <= 1'b1;
              motor_dir_q <= DIR_UP;
              last_dir_q  <= DIR_UP;
            end else begin
              state_q     <= MOVE_DOWN;
              motor_run_q <= 1'b1;
              motor_dir_q <= DIR_DOWN;
              last_dir_q  <= DIR_DOWN;
            end
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (step_tick) begin
            if (step_cnt_q == LAST_STEP) begin
              step_cnt_q  <= '0;
              cur_floor_q <= nf;
              if (pending_q[nf]) begin
                state_q     <= DOOR_OPEN;
                motor_run_q <= 1'b0;
                door_open_q <= 1'b1;
                door_tmr_q  <= DOOR_LOAD;
              end else if (!further) begin
                state_q     <= IDLE;
                motor_run_q <= 1'b0;
              end
            end else begin
              step_cnt_q <= step_cnt_q + SCW'(1);
            end
          end
        end
        DOOR_OPEN: begin
          // A fresh call for the open floor keeps the door open instead of queuing
          if (req_set[cur_floor_q]) begin
            door_tmr_q <= DOOR_LOAD;
          end else if (door_tmr_q <= TW'(1)) begin
            state_q     <= IDLE;
            door_open_q <= 1'b0;
          end else begin
            door_tmr_q <= door_tmr_q - TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign motor_run = motor_run_q;
  assign motor_dir = motor_dir_q;
  assign cur_floor = cur_floor_q;
  assign pending   = pending_q;
  assign door_open = door_open_q;
endmodule
